// File: rtl/argo_block_reducer.sv
// Block reducer: sums each run of BLOCK_LEN accepted words (or a flushed partial run)
// and hands the result downstream on a valid/ready stream.
module argo_block_reducer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BLOCK_LEN = 4,
    parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid,
    output logic             iready,
    input  logic [WIDTH-1:0] datain,
    input  logic             flush,
    output logic             ovalid,
    input  logic             oready,
    output logic [WIDTH-1:0] dataout,
    output logic [CNT_W-1:0] olen,
    output logic             ocarry,
    output logic [31:0]      blocks_out
);

    typedef enum logic {StAccum, StEmit} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               ovalid_q, ovalid_d;
    logic [WIDTH-1:0]   dataout_q, dataout_d;
    logic [CNT_W-1:0]   olen_q, olen_d;
    logic               ocarry_q, ocarry_d;
    logic [31:0]        blocks_q, blocks_d;

    logic               accept;
    logic [WIDTH:0]     sum_full;
    logic [CNT_W-1:0]   cnt_inc;
    logic               close_blk;

    // iready depends only on state, never on oready or ivalid.
    assign iready = (state_q == StAccum) && !rst;
    assign accept = ivalid && iready;

    assign sum_full = {1'b0, acc_q} + {1'b0, datain};
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // A block closes on its last word, or on flush when anything is pending.
    assign close_blk = (accept && (cnt_inc == CNT_W'(BLOCK_LEN)))
                     || (flush && ((cnt_q != '0) || accept));

    // Next-state: accumulate, load the output register on close, release on handoff.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        ovalid_d  = ovalid_q;
        dataout_d = dataout_q;
        olen_d    = olen_q;
        ocarry_d  = ocarry_q;
        blocks_d  = blocks_q;

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d   = sum_full[WIDTH-1:0];
                    cnt_d   = cnt_inc;
                    carry_d = carry_q | sum_full[WIDTH];
                end
                if (close_blk) begin
                    state_d   = StEmit;
                    ovalid_d  = 1'b1;
                    dataout_d = accept ? sum_full[WIDTH-1:0] : acc_q;
                    olen_d    = accept ? cnt_inc : cnt_q;
                    ocarry_d  = accept ? (carry_q | sum_full[WIDTH]) : carry_q;
                    acc_d     = '0;
                    cnt_d     = '0;
                    carry_d   = 1'b0;
                end
            end
            StEmit: begin
                if (ovalid_q && oready) begin
                    ovalid_d = 1'b0;
                    blocks_d = blocks_q + 32'd1;
                    state_d  = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StAccum;
            acc_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            ovalid_q  <= 1'b0;
            dataout_q <= '0;
            olen_q    <= '0;
            ocarry_q  <= 1'b0;
            blocks_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            ovalid_q  <= ovalid_d;
            dataout_q <= dataout_d;
            olen_q    <= olen_d;
            ocarry_q  <= ocarry_d;
            blocks_q  <= blocks_d;
        end
    end

    assign ovalid     = ovalid_q;
    assign dataout    = dataout_q;
    assign olen       = olen_q;
    assign ocarry     = ocarry_q;
    assign blocks_out = blocks_q;

endmodule

// File: tb/tb_argo_block_reducer.sv
// Scoreboarded bench for argo_block_reducer: stimulus pushes expected results,
// a negedge monitor pops and compares each handed-off result.
module tb_argo_block_reducer;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned BLOCK_LEN = 4;
    localparam int unsigned CNT_W     = $clog2(BLOCK_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             ivalid;
    logic             iready;
    logic [WIDTH-1:0] datain;
    logic             flush;
    logic             ovalid;
    logic             oready;
    logic [WIDTH-1:0] dataout;
    logic [CNT_W-1:0] olen;
    logic             ocarry;
    logic [31:0]      blocks_out;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] len;
        logic             carry;
    } res_t;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    argo_block_reducer #(
        .WIDTH    (WIDTH),
        .BLOCK_LEN(BLOCK_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ivalid    (ivalid),
        .iready    (iready),
        .datain    (datain),
        .flush     (flush),
        .ovalid    (ovalid),
        .oready    (oready),
        .dataout   (dataout),
        .olen      (olen),
        .ocarry    (ocarry),
        .blocks_out(blocks_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && ovalid && oready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                check("dataout", dataout, e.data);
                check("olen", 32'(olen), 32'(e.len));
                check("ocarry", 32'(ocarry), 32'(e.carry));
            end
        end
    end

    task automatic push(input logic [31:0] d, input int l, input logic c);
        res_t r;
        r.data  = d;
        r.len   = CNT_W'(l);
        r.carry = c;
        sb_q.push_back(r);
    endtask

    // Offer one word (optionally with flush) until accepted; returns at posedge+1.
    task automatic send(input logic [31:0] d, input logic f);
        logic ok;
        int   n;
        ivalid = 1'b1;
        datain = d;
        flush  = f;
        n      = 0;
        forever begin
            @(negedge clk);
            ok = iready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        ivalid = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for the pending result to be handed off and the block to reopen.
    task automatic wait_idle();
        int n;
        n = 0;
        while (ovalid || !iready) begin
            cycle();
            n++;
            if (n > 50) begin
                check("idle_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        ivalid = 1'b0;
        datain = '0;
        flush  = 1'b0;
        oready = 1'b1;
        #12;
        check("rst_iready", 32'(iready), 32'd0);
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_dataout", dataout, 32'd0);
        check("rst_olen", 32'(olen), 32'd0);
        check("rst_ocarry", 32'(ocarry), 32'd0);
        check("rst_blocks", blocks_out, 32'd0);
        #10;
        rst = 1'b0;
        cycle();
        check("post_rst_iready", 32'(iready), 32'd1);

        // Full block, back-to-back words.
        push(32'h0000000A, 4, 1'b0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        check("t1_ovalid_hi", 32'(ovalid), 32'd1);
        check("t1_iready_lo", 32'(iready), 32'd0);
        cycle();
        check("t1_ovalid_1cyc", 32'(ovalid), 32'd0);
        check("t1_iready_back", 32'(iready), 32'd1);
        check("t1_blocks", blocks_out, 32'd1);

        // Carry out of the top bit.
        push(32'h00000001, 4, 1'b1);
        send(32'hFFFFFFFF, 1'b0);
        send(32'd2, 1'b0);
        send(32'd0, 1'b0);
        send(32'd0, 1'b0);
        wait_idle();
        check("t2_blocks", blocks_out, 32'd2);

        // Backpressure: result held, offered words not consumed.
        oready = 1'b0;
        push(32'h00000094, 4, 1'b0);
        for (int i = 0; i < 4; i++) send(32'h25, 1'b0);
        ivalid = 1'b1;
        datain = 32'h11;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_ovalid", 32'(ovalid), 32'd1);
            check("bp_dataout", dataout, 32'h94);
            check("bp_iready", 32'(iready), 32'd0);
        end
        check("bp_blocks", blocks_out, 32'd3 - 32'd1 + 32'd0);
        oready = 1'b1;
        push(32'h00000044, 4, 1'b0);
        for (int i = 0; i < 4; i++) send(32'h11, 1'b0);
        wait_idle();
        check("bp_blocks_after", blocks_out, 32'd4);

        // Flush a partial block with no word on that edge.
        push(32'h0000007A, 2, 1'b0);
        send(32'h25, 1'b0);
        send(32'h55, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_ovalid", 32'(ovalid), 32'd1);
        wait_idle();
        check("fl_blocks", blocks_out, 32'd5);
        // Flush on an empty block is ignored.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_empty_ovalid", 32'(ovalid), 32'd0);
        cycle();
        check("fl_empty_ovalid2", 32'(ovalid), 32'd0);
        check("fl_empty_blocks", blocks_out, 32'd5);

        // Flush coincident with an accepted word.
        push(32'h00000030, 2, 1'b0);
        send(32'h10, 1'b0);
        send(32'h20, 1'b1);
        wait_idle();
        check("flw_blocks", blocks_out, 32'd6);
        // Flush on the BLOCK_LEN-th word: exactly one result.
        push(32'h00000004, 4, 1'b0);
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        send(32'd1, 1'b1);
        wait_idle();
        cycle();
        cycle();
        check("flf_ovalid", 32'(ovalid), 32'd0);
        check("flf_blocks", blocks_out, 32'd7);

        // Asynchronous reset mid-block discards the partial sum.
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("ar_ovalid", 32'(ovalid), 32'd0);
        check("ar_iready", 32'(iready), 32'd0);
        check("ar_blocks", blocks_out, 32'd0);
        #20;
        rst = 1'b0;
        cycle();
        push(32'h00000004, 4, 1'b0);
        for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
        wait_idle();
        check("ar_blocks_after", blocks_out, 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
